move_sequencer: RTL and testbench

Generates the boss dance-move stream for the game: while a round is running it issues a pseudo-random move, holds it for one beat, and waits for the judge's hit acknowledge. Sits upstream of the judge/compare logic in the top level as the transmitting end of the boss-move ↔ player-match interface. Outputs feed the boss dot-matrix renderer and the correctness compare. It also reports per-move misses to the score block.

---
 rtl/move_sequencer_if.sv | 31 +++
 rtl/move_sequencer.sv | 123 ++++++++++++
 tb/tb_move_sequencer.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/move_sequencer_if.sv
// Boss-move <-> player-match link between the move sequencer and the judge.
// The master (sequencer) drives the move stream; the slave (judge/score side) drives start and hit.
interface move_sequencer_if;
  logic       start;
  logic       hit;
  logic [1:0] move;
  logic       move_valid;
  logic       beat;
  logic       missed;
  logic [7:0] seq_count;

  modport master (
    input  start,
    input  hit,
    output move,
    output move_valid,
    output beat,
    output missed,
    output seq_count
  );

  modport slave (
    output start,
    output hit,
    input  move,
    input  move_valid,
    input  beat,
    input  missed,
    input  seq_count
  );
endinterface

// File: rtl/move_sequencer.sv
// Boss dance-move generator: LFSR-driven moves shown for a beat, a neutral gap, and per-move miss reporting.
// Optional MOVE_NOREPEAT_EN macro: never show the same move twice in a row.
module move_sequencer #(
  parameter int       BEAT_CYCLES = 25000000,
  parameter int       GAP_CYCLES  = 5000000,
  parameter bit [7:0] SEED        = 8'hA5
) (
  input  logic                   clk,
  input  logic                   reset,
  move_sequencer_if.master       bus
);

  localparam int       MAX_CYCLES = (BEAT_CYCLES > GAP_CYCLES) ? BEAT_CYCLES : GAP_CYCLES;
  localparam int       TW         = (MAX_CYCLES > 2) ? $clog2(MAX_CYCLES) : 1;
  localparam bit [7:0] SEED_INIT  = (SEED == 8'h00) ? 8'h01 : SEED;
  localparam logic [TW-1:0] BEAT_LAST = TW'(BEAT_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LAST  = TW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHOW,
    GAP
  } state_t;

  state_t        r_state;
  logic [7:0]    r_lfsr;
  logic [TW-1:0] r_timer;
  logic [1:0]    r_move;
  logic          r_valid;
  logic          r_beat;
  logic          r_missed;
  logic [7:0]    r_seqCount;

  logic [7:0]    w_lfsrNext;
  logic [1:0]    w_candidate;
  logic [1:0]    w_issue;
  logic [7:0]    w_seqNext;
  logic          w_enterShow;
  logic          w_showEnd;

  assign w_lfsrNext = {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};

  // Fall back to the upper pair, then to "left", so a move is never neutral.
  assign w_candidate = (w_lfsrNext[1:0] != 2'b00) ? w_lfsrNext[1:0] :
                       (w_lfsrNext[3:2] != 2'b00) ? w_lfsrNext[3:2] : 2'b01;

`ifdef MOVE_NOREPEAT_EN
  logic [1:0] r_prevMove;

  assign w_issue = (w_candidate != r_prevMove) ? w_candidate :
                   (w_candidate == 2'd3)       ? 2'd1 : w_candidate + 2'd1;
`else
  assign w_issue = w_candidate;
`endif

  // A fresh round always counts from 1; within a round the count saturates.
  assign w_seqNext   = (r_state == IDLE)       ? 8'd1 :
                       (r_seqCount == 8'hFF)   ? r_seqCount : r_seqCount + 8'd1;
  assign w_enterShow = (r_state == IDLE) || ((r_state == GAP) && (r_timer == GAP_LAST));
  assign w_showEnd   = bus.hit || (r_timer == BEAT_LAST);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_lfsr     <= SEED_INIT;
      r_timer    <= '0;
      r_move     <= 2'd0;
      r_valid    <= 1'b0;
      r_beat     <= 1'b0;
      r_missed   <= 1'b0;
      r_seqCount <= 8'd0;
`ifdef MOVE_NOREPEAT_EN
      r_prevMove <= 2'd0;
`endif
    end else begin
      r_beat   <= 1'b0;
      r_missed <= 1'b0;
      if (!bus.start) begin
        r_state <= IDLE;
        r_timer <= '0;
        r_move  <= 2'd0;
        r_valid <= 1'b0;
`ifdef MOVE_NOREPEAT_EN
        r_prevMove <= 2'd0;
`endif
      end else if (w_enterShow) begin
        r_state    <= SHOW;
        r_lfsr     <= w_lfsrNext;
        r_timer    <= '0;
        r_move     <= w_issue;
        r_valid    <= 1'b1;
        r_beat     <= 1'b1;
        r_seqCount <= w_seqNext;
`ifdef MOVE_NOREPEAT_EN
        r_prevMove <= w_issue;
`endif
      end else begin
        case (r_state)
          SHOW: begin
            if (w_showEnd) begin
              r_state  <= GAP;
              r_timer  <= '0;
              r_move   <= 2'd0;
              r_valid  <= 1'b0;
              r_missed <= ~bus.hit;
            end else begin
              r_timer <= r_timer + 1'b1;
            end
          end
          GAP:     r_timer <= r_timer + 1'b1;
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign bus.move       = r_move;
  assign bus.move_valid = r_valid;
  assign bus.beat       = r_beat;
  assign bus.missed     = r_missed;
  assign bus.seq_count  = r_seqCount;

endmodule

// File: tb/tb_move_sequencer.sv
// Directed self-checking bench for move_sequencer with BEAT_CYCLES=8, GAP_CYCLES=4, SEED=8'hA5.
// Build with MOVE_NOREPEAT_EN defined to also exercise the no-repeat option.
module tb_move_sequencer;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  move_sequencer_if bus ();

  move_sequencer #(
    .BEAT_CYCLES (8),
    .GAP_CYCLES  (4),
    .SEED        (8'hA5)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef MOVE_NOREPEAT_EN
  localparam logic [1:0] MOVE5 = 2'd2;
  localparam logic [1:0] MOVE7 = 2'd1;
`else
  localparam logic [1:0] MOVE5 = 2'd1;
  localparam logic [1:0] MOVE7 = 2'd3;
`endif

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic s, input logic h, input logic r);
    bus.start = s;
    bus.hit   = h;
    reset     = r;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkState(input string tag, input logic [1:0] mv, input logic vld,
                            input logic bt, input logic ms);
    checkOutput({tag, ".move"},   8'(bus.move),       8'(mv));
    checkOutput({tag, ".valid"},  8'(bus.move_valid), 8'(vld));
    checkOutput({tag, ".beat"},   8'(bus.beat),       8'(bt));
    checkOutput({tag, ".missed"}, 8'(bus.missed),     8'(ms));
  endtask

  initial begin
    logic [1:0] expSeq [4];
    logic [1:0] prevMove;
    expSeq   = '{2'd2, 2'd1, 2'd2, 2'd1};
    prevMove = 2'd0;
    errors   = 0;
    checks   = 0;

    // Reset with the round stopped
    applyStimulus(1'b0, 1'b0, 1'b0);
    repeat (2) stepCycle();
    checkState("reset", 2'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("reset.seq", bus.seq_count, 8'd0);

    // Unhit moves: 8-cycle show, miss pulse on first gap cycle, 4-cycle gap
    applyStimulus(1'b1, 1'b0, 1'b1);
    stepCycle();
    for (int m = 0; m < 4; m++) begin
      checkState($sformatf("mv%0d.entry", m), expSeq[m], 1'b1, 1'b1, 1'b0);
      checkOutput($sformatf("mv%0d.seq", m), bus.seq_count, 8'(m + 1));
      for (int c = 1; c < 8; c++) begin
        stepCycle();
        checkState($sformatf("mv%0d.show%0d", m, c), expSeq[m], 1'b1, 1'b0, 1'b0);
      end
      stepCycle();
      checkState($sformatf("mv%0d.miss", m), 2'd0, 1'b0, 1'b0, 1'b1);
      for (int g = 1; g < 4; g++) begin
        stepCycle();
        checkState($sformatf("mv%0d.gap%0d", m, g), 2'd0, 1'b0, 1'b0, 1'b0);
      end
      stepCycle();
    end

    // Hit on the third show cycle
    checkState("hit3.entry", MOVE5, 1'b1, 1'b1, 1'b0);
    checkOutput("hit3.seq", bus.seq_count, 8'd5);
    repeat (2) stepCycle();
    applyStimulus(1'b1, 1'b1, 1'b1);
    stepCycle();
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkState("hit3.drop", 2'd0, 1'b0, 1'b0, 1'b0);
    for (int g = 1; g < 4; g++) begin
      stepCycle();
      checkState($sformatf("hit3.gap%0d", g), 2'd0, 1'b0, 1'b0, 1'b0);
    end
    stepCycle();
    checkState("hit3.next", 2'd3, 1'b1, 1'b1, 1'b0);
    checkOutput("hit3.nextseq", bus.seq_count, 8'd6);

    // Hit coincident with the timeout cycle counts as a hit
    repeat (7) stepCycle();
    checkState("hit8.pre", 2'd3, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1);
    stepCycle();
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkState("hit8.gap", 2'd0, 1'b0, 1'b0, 1'b0);
    repeat (3) stepCycle();
    stepCycle();
    checkState("hit8.next", MOVE7, 1'b1, 1'b1, 1'b0);
    checkOutput("hit8.seq", bus.seq_count, 8'd7);

    // Drop start on the timeout cycle: no miss, count held, then a fresh round
    repeat (7) stepCycle();
    applyStimulus(1'b0, 1'b0, 1'b1);
    stepCycle();
    checkState("drop", 2'd0, 1'b0, 1'b0, 1'b0);
    stepCycle();
    checkState("idle", 2'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("idle.seq", bus.seq_count, 8'd7);
    applyStimulus(1'b1, 1'b0, 1'b1);
    stepCycle();
    checkState("restart", 2'd2, 1'b1, 1'b1, 1'b0);
    checkOutput("restart.seq", bus.seq_count, 8'd1);

    // Reset mid-gap together with hit
    repeat (8) stepCycle();
    checkState("rgap.miss", 2'd0, 1'b0, 1'b0, 1'b1);
    stepCycle();
    applyStimulus(1'b1, 1'b1, 1'b0);
    stepCycle();
    checkState("rst", 2'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("rst.seq", bus.seq_count, 8'd0);
    applyStimulus(1'b1, 1'b0, 1'b1);
    stepCycle();
    checkState("rst.first", 2'd2, 1'b1, 1'b1, 1'b0);
    checkOutput("rst.seq1", bus.seq_count, 8'd1);
    stepCycle();
    checkState("rst.second", 2'd2, 1'b1, 1'b0, 1'b0);

`ifdef MOVE_NOREPEAT_EN
    // Fast hit-driven run: consecutive moves must always differ
    prevMove = bus.move;
    for (int n = 0; n < 200; n++) begin
      applyStimulus(1'b1, 1'b1, 1'b1);
      stepCycle();
      applyStimulus(1'b1, 1'b0, 1'b1);
      repeat (4) stepCycle();
      checkOutput($sformatf("norep%0d", n), 8'(bus.move != prevMove), 8'd1);
      prevMove = bus.move;
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
